// File: rtl/des_expand_keymix.sv
// des_expand_keymix: DES expansion E(R) xor round subkey, registered behind a valid/ready stage.
// Define DES_KEYMIX_XFER_CNT_EN to add the 16-bit output transfer counter port xfer_cnt.
module des_expand_keymix #(
    parameter int USE_SKID = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] r_in,
    input  logic [47:0] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] sbox_in
`ifdef DES_KEYMIX_XFER_CNT_EN
    ,
    output logic [15:0] xfer_cnt
`endif
);
    logic [47:0] e;
    logic [47:0] mixed;
    logic [47:0] skid_data;
    logic        skid_valid;
    logic        accept;

    // E bit j+1 of S-box group j/6 takes DES bit 4*(j/6)+(j%6), wrapping 0->32 and 33->1
    genvar j;
    for (j = 0; j < 48; j++) begin : g_e
        localparam int D = (4 * (j / 6) + j % 6 + 31) % 32 + 1;
        assign e[47 - j] = r_in[32 - D];
    end

    assign mixed    = e ^ subkey;
    assign in_ready = (USE_SKID != 0) ? ~skid_valid : (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // Skid only ever fills when the main register is stalled, so with USE_SKID=0 it stays empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            sbox_in    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_valid && !out_ready) begin
            if (accept) begin
                skid_valid <= 1'b1;
                skid_data  <= mixed;
            end
        end else if (skid_valid) begin
            sbox_in    <= skid_data;
            skid_valid <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) sbox_in <= mixed;
        end
    end

`ifdef DES_KEYMIX_XFER_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xfer_cnt <= '0;
        else if (out_valid && out_ready && !flush) xfer_cnt <= xfer_cnt + 16'd1;
    end
`endif
endmodule
